// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB3 bus bundle for apb_cmd_master.
// master modport: the view of apb_cmd_master (drives cmd_ready, rsp_*, APB requests).
// slave modport:  the view of the agent + peripheral fabric (drives cmd_*, rsp_ready, APB replies).
//
// Signals:
//   cmd_valid/cmd_ready, cmd_addr, cmd_write, cmd_wdata, cmd_prot  command stream
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err, rsp_timeout           response stream
//   paddr, psel, penable, pwrite, pwdata, pprot                     APB request
//   prdata, pready, pslverr                                         APB reply
interface apb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // command stream
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_wdata;
    logic [2:0]        cmd_prot;

    // response stream
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // APB3 bus
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [2:0]        pprot;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output paddr, psel, penable, pwrite, pwdata, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  paddr, psel, penable, pwrite, pwdata, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Purpose:      APB3 initiator turning a valid/ready command stream into single APB transfers.
// Latency:      accept at edge T -> SETUP T..T+1, ACCESS T+1..T+2, rsp_valid after T+2 (+1 per wait state).
// Backpressure: one transfer in flight; cmd_ready low from accept until the response handshake.
//
// Ports:
//   pclk    APB clock, all logic on the rising edge
//   preset  synchronous active-high reset
//   bus     apb_cmd_master_if.master: command stream in, response stream out, APB3 bus
//   busy    high whenever the FSM is not IDLE
//
// Optional feature macro: APB_CMD_MASTER_TIMEOUT_EN
//   defined:   ACCESS is aborted after TIMEOUT_CYC cycles of pready=0 (rsp_err=1, rsp_timeout=1)
//   undefined: ACCESS waits indefinitely, rsp_timeout is constant 0, TIMEOUT_CYC has no effect
module apb_cmd_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  pclk,
    input  logic                  preset,
    apb_cmd_master_if.master      bus,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Latched command, driven straight onto the APB request lines. These
    // keep their last value between transfers.
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [2:0]        pprot_q;

    // Captured response, held for the whole RESP phase.
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              tmo_q;

    logic cmd_accept;
    logic access_done;
    logic timeout_hit;

    assign cmd_accept  = (state_q == IDLE)   && bus.cmd_valid;
    // pready is only meaningful while in ACCESS; elsewhere it is ignored.
    assign access_done = (state_q == ACCESS) && bus.pready;

    // ------------------------------------------------------------------
    // Optional ACCESS-phase watchdog
    // ------------------------------------------------------------------
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] to_cnt_q;

    // Counts ACCESS cycles that end without pready. Cleared when the
    // command is accepted, i.e. on the way into SETUP.
    always_ff @(posedge pclk) begin
        if (preset) begin
            to_cnt_q <= '0;
        end else if (cmd_accept) begin
            to_cnt_q <= '0;
        end else if ((state_q == ACCESS) && !bus.pready) begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

    // A pready arriving on the terminal-count cycle takes priority, so the
    // abort condition requires pready to still be low.
    assign timeout_hit = (state_q == ACCESS) && !bus.pready && (to_cnt_q == TO_LAST);

    always_ff @(posedge pclk) begin
        if (preset) begin
            tmo_q <= 1'b0;
        end else if (access_done) begin
            tmo_q <= 1'b0;
        end else if (timeout_hit) begin
            tmo_q <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign tmo_q              = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (access_done || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the current state
    // psel/penable come straight from state_q, so a reset mid-transfer
    // drops them on the same edge that returns the FSM to IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.psel      = 1'b0;
        bus.penable   = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
            end
            SETUP: begin
                bus.psel = 1'b1;
                busy     = 1'b1;
            end
            ACCESS: begin
                bus.psel    = 1'b1;
                bus.penable = 1'b1;
                busy        = 1'b1;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                busy          = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (preset) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pprot_q  <= 3'b000;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            // The address goes out whole; no alignment is enforced.
            if (cmd_accept) begin
                paddr_q  <= bus.cmd_addr;
                pwrite_q <= bus.cmd_write;
                pwdata_q <= bus.cmd_wdata;
                pprot_q  <= bus.cmd_prot;
            end

            if (access_done) begin
                // Writes return zero data regardless of what the slave drives.
                rdata_q <= pwrite_q ? '0 : bus.prdata;
                err_q   <= bus.pslverr;
            end else if (timeout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pprot       = pprot_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: a cycle engine drives commands, models
// the APB slave and the response consumer, and checks responses against a queue
// of expected results pushed when each command is accepted.
`timescale 1ns/1ps
module tb_apb_cmd_master;

    localparam int TO = 8;

    logic pclk = 1'b0;
    logic preset;
    logic busy;

    always #5 pclk = ~pclk;

    apb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_cmd_master #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT_CYC(TO)
    ) dut (
        .pclk  (pclk),
        .preset(preset),
        .bus   (bus),
        .busy  (busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [2:0]  prot;
        int          waits;   // ACCESS cycles with pready=0 before completion
        bit          hang;    // slave never raises pready
        logic [31:0] rdata;
        logic        err;
        int          delay;   // RESP cycles with rsp_ready=0 before consuming
    } cmd_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          lat;     // cycle at which rsp_valid must first be seen
        int          access;  // expected number of ACCESS cycles
        int          delay;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    cmd_t cmd_q[$];
    exp_t exp_q[$];
    int   acc_log[$];
    cmd_t cur;
    bit   in_xfer  = 0;
    bit   rsp_seen = 0;
    int   acc_cyc  = 0;
    int   psel_cnt = 0;
    int   pen_cnt  = 0;
    int   hold_cnt = 0;

    function automatic cmd_t mk(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                                input logic [2:0] prot, input int waits, input bit hang,
                                input logic [31:0] rdata, input logic err, input int delay);
        cmd_t c;
        c.addr = addr; c.write = write; c.wdata = wdata; c.prot = prot;
        c.waits = waits; c.hang = hang; c.rdata = rdata; c.err = err; c.delay = delay;
        return c;
    endfunction

    task automatic drive_idle();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = '0;
        bus.cmd_prot  = 3'b000;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
    endtask

    // One iteration per negedge: check outputs, play consumer, slave and producer.
    task automatic run_engine(input int budget);
        int   n = 0;
        exp_t e;
        bit   busy_exp;
        while ((cmd_q.size() > 0 || exp_q.size() > 0 || in_xfer) && n < budget) begin
            @(negedge pclk);
            cyc++;
            n++;
            busy_exp = in_xfer || (exp_q.size() > 0);
            checks++; if (busy !== busy_exp) begin errors++; $display("FAIL busy @%0d: got %b expected %b", cyc, busy, busy_exp); end

            // APB request side
            if (in_xfer && !bus.rsp_valid) begin
                psel_cnt++;
                checks++; if (bus.psel !== 1'b1) begin errors++; $display("FAIL psel @%0d: got %b expected 1", cyc, bus.psel); end
                if (psel_cnt == 1) begin
                    checks++; if (bus.penable !== 1'b0) begin errors++; $display("FAIL setup_penable @%0d: got %b expected 0", cyc, bus.penable); end
                    checks++; if (cyc !== acc_cyc + 1) begin errors++; $display("FAIL setup_cycle: got %0d expected %0d", cyc, acc_cyc + 1); end
                end else begin
                    checks++; if (bus.penable !== 1'b1) begin errors++; $display("FAIL access_penable @%0d: got %b expected 1", cyc, bus.penable); end
                end
                if (bus.psel && bus.penable) pen_cnt++;
                checks++; if (bus.paddr !== cur.addr) begin errors++; $display("FAIL paddr @%0d: got %h expected %h", cyc, bus.paddr, cur.addr); end
                checks++; if (bus.pwrite !== cur.write) begin errors++; $display("FAIL pwrite @%0d: got %b expected %b", cyc, bus.pwrite, cur.write); end
                checks++; if (bus.pwdata !== cur.wdata) begin errors++; $display("FAIL pwdata @%0d: got %h expected %h", cyc, bus.pwdata, cur.wdata); end
                checks++; if (bus.pprot !== cur.prot) begin errors++; $display("FAIL pprot @%0d: got %b expected %b", cyc, bus.pprot, cur.prot); end
            end else begin
                checks++; if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin errors++; $display("FAIL apb_idle @%0d: got psel=%b penable=%b expected 0/0", cyc, bus.psel, bus.penable); end
            end

            // response consumer
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_rsp @%0d: got rsp_valid=1 expected 0", cyc);
                    bus.rsp_ready = 1'b1;
                end else begin
                    e = exp_q[0];
                    if (!rsp_seen) begin
                        rsp_seen = 1; in_xfer = 0; hold_cnt = 0;
                        checks++; if (cyc !== e.lat) begin errors++; $display("FAIL rsp_latency: got %0d expected %0d", cyc, e.lat); end
                        checks++; if (pen_cnt !== e.access) begin errors++; $display("FAIL access_cycles: got %0d expected %0d", pen_cnt, e.access); end
                        checks++; if (psel_cnt !== e.access + 1) begin errors++; $display("FAIL psel_cycles: got %0d expected %0d", psel_cnt, e.access + 1); end
                    end
                    checks++; if (bus.rsp_rdata !== e.rdata) begin errors++; $display("FAIL rsp_rdata @%0d: got %h expected %h", cyc, bus.rsp_rdata, e.rdata); end
                    checks++; if (bus.rsp_err !== e.err) begin errors++; $display("FAIL rsp_err @%0d: got %b expected %b", cyc, bus.rsp_err, e.err); end
                    checks++; if (bus.rsp_timeout !== e.tmo) begin errors++; $display("FAIL rsp_timeout @%0d: got %b expected %b", cyc, bus.rsp_timeout, e.tmo); end
                    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL cmd_ready_in_resp @%0d: got %b expected 0", cyc, bus.cmd_ready); end
                    if (hold_cnt >= e.delay) begin
                        bus.rsp_ready = 1'b1;
                        exp_q.delete(0);
                        rsp_seen = 0;
                    end else begin
                        bus.rsp_ready = 1'b0;
                        hold_cnt++;
                    end
                end
            end else begin
                bus.rsp_ready = 1'($urandom_range(0, 1));
            end

            // APB slave: outside ACCESS the reply lines carry noise the DUT must ignore
            if (bus.psel && bus.penable && in_xfer) begin
                if (!cur.hang && pen_cnt > cur.waits) begin
                    bus.pready = 1'b1; bus.prdata = cur.rdata; bus.pslverr = cur.err;
                end else begin
                    bus.pready = 1'b0; bus.prdata = $urandom; bus.pslverr = 1'($urandom_range(0, 1));
                end
            end else begin
                bus.pready = 1'($urandom_range(0, 1)); bus.prdata = $urandom; bus.pslverr = 1'($urandom_range(0, 1));
            end

            // command producer: cmd_valid stays high while commands are queued
            if (cmd_q.size() > 0) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_addr  = cmd_q[0].addr;
                bus.cmd_write = cmd_q[0].write;
                bus.cmd_wdata = cmd_q[0].wdata;
                bus.cmd_prot  = cmd_q[0].prot;
                if (bus.cmd_ready === 1'b1) begin
                    checks++; if (exp_q.size() != 0 || in_xfer) begin errors++; $display("FAIL accept_while_busy @%0d: got pending=%0d expected 0", cyc, exp_q.size()); end
                    cur = cmd_q.pop_front();
                    in_xfer = 1; acc_cyc = cyc; psel_cnt = 0; pen_cnt = 0;
                    acc_log.push_back(cyc);
                    e.access = cur.hang ? TO : cur.waits + 1;
                    e.rdata  = (cur.hang || cur.write) ? 32'h0 : cur.rdata;
                    e.err    = cur.hang ? 1'b1 : cur.err;
                    e.tmo    = cur.hang;
                    e.lat    = cyc + 2 + e.access;
                    e.delay  = cur.delay;
                    exp_q.push_back(e);
                end
            end else begin
                bus.cmd_valid = 1'b0;
                bus.cmd_addr  = $urandom;
                bus.cmd_write = 1'($urandom_range(0, 1));
                bus.cmd_wdata = $urandom;
                bus.cmd_prot  = 3'($urandom_range(0, 7));
            end
        end
        if (cmd_q.size() > 0 || exp_q.size() > 0 || in_xfer) begin
            checks++; errors++;
            $display("FAIL engine_budget: got %0d cmds and %0d rsps outstanding expected 0", cmd_q.size(), exp_q.size());
            cmd_q.delete(); exp_q.delete(); in_xfer = 0; rsp_seen = 0;
        end
        @(negedge pclk);
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        preset = 1'b1;
        repeat (3) @(negedge pclk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
        checks++; if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin errors++; $display("FAIL reset_psel_penable: got %b%b expected 00", bus.psel, bus.penable); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0) begin errors++; $display("FAIL reset_paddr_pwdata: got %h/%h expected 0/0", bus.paddr, bus.pwdata); end
        checks++; if (bus.pwrite !== 1'b0 || bus.pprot !== 3'b000) begin errors++; $display("FAIL reset_pwrite_pprot: got %b/%b expected 0/000", bus.pwrite, bus.pprot); end
        checks++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_fields: got %h/%b/%b expected 0/0/0", bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout);
        end
        preset = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_zero_wait_write();
        cmd_q.push_back(mk(32'h4001_1000, 1'b1, 32'hA5A5_5A5A, 3'b010, 0, 0, 32'hDEAD_BEEF, 1'b0, 0));
        run_engine(200);
    endtask

    task automatic test_wait_read();
        cmd_q.push_back(mk(32'h4001_1004, 1'b0, 32'h1111_2222, 3'b001, 3, 0, 32'h1234_5678, 1'b0, 0));
        run_engine(200);
    endtask

    task automatic test_err_backpressure();
        acc_log.delete();
        cmd_q.push_back(mk(32'h4001_1008, 1'b1, 32'h0F0F_F0F0, 3'b100, 0, 0, 32'h5555_AAAA, 1'b1, 5));
        cmd_q.push_back(mk(32'h4001_100C, 1'b0, 32'h0, 3'b000, 0, 0, 32'h7777_8888, 1'b0, 0));
        run_engine(200);
        checks++;
        if (acc_log.size() != 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", acc_log.size()); end
        else if (acc_log[1] - acc_log[0] != 9) begin errors++; $display("FAIL bp_accept_gap: got %0d expected 9", acc_log[1] - acc_log[0]); end
    endtask

    task automatic test_back_to_back();
        acc_log.delete();
        cmd_q.push_back(mk(32'h4001_2000, 1'b0, 32'h0, 3'b000, 0, 0, 32'hAAAA_0001, 1'b0, 0));
        cmd_q.push_back(mk(32'h4001_2003, 1'b1, 32'hBBBB_0002, 3'b111, 0, 0, 32'h0, 1'b0, 0));
        cmd_q.push_back(mk(32'h4001_2008, 1'b0, 32'h0, 3'b011, 0, 0, 32'hCCCC_0003, 1'b0, 0));
        run_engine(200);
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (acc_log.size() != 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", acc_log.size()); end
            else if (acc_log[i] - acc_log[i-1] != 4) begin errors++; $display("FAIL b2b_period[%0d]: got %0d expected 4", i, acc_log[i] - acc_log[i-1]); end
        end
    endtask

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        cmd_q.push_back(mk(32'h4001_3000, 1'b0, 32'h0, 3'b000, 0, 1, 32'hFFFF_FFFF, 1'b0, 0));
        cmd_q.push_back(mk(32'h4001_3004, 1'b0, 32'h0, 3'b000, TO - 1, 0, 32'h0BAD_BEEF, 1'b0, 1));
        run_engine(300);
    endtask
`else
    task automatic test_long_stall();
        cmd_q.push_back(mk(32'h4001_3000, 1'b0, 32'h0, 3'b000, 20, 0, 32'hCAFE_F00D, 1'b0, 2));
        run_engine(300);
    endtask
`endif

    task automatic test_reset_mid();
        int n = 0;
        @(negedge pclk);
        bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h4001_4000; bus.cmd_write = 1'b0;
        bus.cmd_wdata = 32'h0; bus.cmd_prot = 3'b000; bus.pready = 1'b0; bus.rsp_ready = 1'b1;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        while (!(bus.psel && bus.penable) && n < 10) begin @(negedge pclk); n++; end
        checks++; if (!(bus.psel && bus.penable)) begin errors++; $display("FAIL rmid_reach_access: got psel=%b penable=%b expected 1/1", bus.psel, bus.penable); end
        repeat (2) @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        checks++; if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin errors++; $display("FAIL rmid_psel_penable: got %b%b expected 00", bus.psel, bus.penable); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_cmd_ready: got %b expected 1", bus.cmd_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.paddr !== 32'h0) begin errors++; $display("FAIL rmid_paddr: got %h expected 0", bus.paddr); end
        preset = 1'b0;
        bus.pready = 1'b1; bus.prdata = 32'h9999_9999;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp[%0d]: got rsp_valid=%b busy=%b expected 0/0", i, bus.rsp_valid, busy); end
        end
        drive_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_err_backpressure();
        test_back_to_back();
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_long_stall();
`endif
        test_reset_mid();
        test_zero_wait_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
